// File: rtl/collision_response.sv
// Snake game controller: turns apple/body collision flags into growth,
// BCD scoring, an apple relocation handshake and the game state machine.
module collision_response #(
    parameter int INIT_LEN = 3,
    parameter int MAX_LEN  = 50
) (
    input  logic       clk,
    input  logic       nRst,
    input  logic       start,
    input  logic       moveTick,
    input  logic       goodColl,
    input  logic       badColl,
    input  logic       appleAck,
    output logic [1:0] state,
    output logic       grow,
    output logic       appleReq,
    output logic [6:0] length,
    output logic [3:0] scoreOnes,
    output logic [3:0] scoreTens,
    output logic       gameOver,
    output logic       win
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_OVER = 2'd2,
        ST_WIN  = 2'd3
    } state_t;

    localparam logic [6:0] LP_INIT = 7'(INIT_LEN);
    localparam logic [6:0] LP_MAX  = 7'(MAX_LEN);

    state_t     r_state,    w_stateN;
    logic       r_startQ;
    logic       r_goodSeen, w_goodSeenN;
    logic       r_badSeen,  w_badSeenN;
    logic       r_grow,     w_growN;
    logic       r_appleReq, w_appleReqN;
    logic [6:0] r_length,   w_lengthN;
    logic [3:0] r_ones,     w_onesN;
    logic [3:0] r_tens,     w_tensN;

    logic       w_startEdge;
    logic       w_goodNow;
    logic       w_goodEff;
    logic       w_badEff;
    logic [6:0] w_lenInc;
    logic [3:0] w_onesInc;
    logic [3:0] w_tensInc;

    assign w_startEdge = start & ~r_startQ;
    // An apple already being relocated must not be eaten again
    assign w_goodNow   = goodColl & ~r_appleReq;
    assign w_goodEff   = r_goodSeen | w_goodNow;
    assign w_badEff    = r_badSeen | badColl;
    assign w_lenInc    = r_length + 7'd1;

    always_comb begin
        w_onesInc = r_ones + 4'd1;
        w_tensInc = r_tens;
        if (r_ones == 4'd9) begin
            w_onesInc = 4'd0;
            w_tensInc = (r_tens == 4'd9) ? 4'd0 : r_tens + 4'd1;
        end
    end

    always_comb begin
        w_stateN    = r_state;
        w_goodSeenN = r_goodSeen;
        w_badSeenN  = r_badSeen;
        w_growN     = 1'b0;
        w_appleReqN = r_appleReq;
        w_lengthN   = r_length;
        w_onesN     = r_ones;
        w_tensN     = r_tens;

        if (r_appleReq && appleAck) begin
            w_appleReqN = 1'b0;
        end

        unique case (r_state)
            ST_IDLE: begin
                if (w_startEdge) begin
                    w_stateN    = ST_RUN;
                    w_lengthN   = LP_INIT;
                    w_onesN     = 4'd0;
                    w_tensN     = 4'd0;
                    w_goodSeenN = 1'b0;
                    w_badSeenN  = 1'b0;
                    w_appleReqN = 1'b0;
                end
            end
            ST_RUN: begin
                if (moveTick) begin
                    w_goodSeenN = 1'b0;
                    w_badSeenN  = 1'b0;
                    if (w_badEff) begin
                        w_stateN = ST_OVER;
                    end else if (w_goodEff) begin
                        w_growN     = 1'b1;
                        w_lengthN   = w_lenInc;
                        w_onesN     = w_onesInc;
                        w_tensN     = w_tensInc;
                        w_appleReqN = 1'b1;
                        if (w_lenInc == LP_MAX) begin
                            w_stateN = ST_WIN;
                        end
                    end
                end else begin
                    w_goodSeenN = r_goodSeen | w_goodNow;
                    w_badSeenN  = r_badSeen | badColl;
                end
            end
            ST_OVER, ST_WIN: begin
                if (w_startEdge) begin
                    w_stateN = ST_IDLE;
                end
            end
            default: begin
                w_stateN = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            r_state    <= ST_IDLE;
            r_startQ   <= 1'b1;
            r_goodSeen <= 1'b0;
            r_badSeen  <= 1'b0;
            r_grow     <= 1'b0;
            r_appleReq <= 1'b0;
            r_length   <= LP_INIT;
            r_ones     <= 4'd0;
            r_tens     <= 4'd0;
        end else begin
            r_state    <= w_stateN;
            r_startQ   <= start;
            r_goodSeen <= w_goodSeenN;
            r_badSeen  <= w_badSeenN;
            r_grow     <= w_growN;
            r_appleReq <= w_appleReqN;
            r_length   <= w_lengthN;
            r_ones     <= w_onesN;
            r_tens     <= w_tensN;
        end
    end

    assign state     = r_state;
    assign grow      = r_grow;
    assign appleReq  = r_appleReq;
    assign length    = r_length;
    assign scoreOnes = r_ones;
    assign scoreTens = r_tens;
    assign gameOver  = (r_state == ST_OVER);
    assign win       = (r_state == ST_WIN);

endmodule

// File: tb/tb_collision_response.sv
// Bench for collision_response: vector table plus hand-written sequences
// on a long-game instance and a short MAX_LEN=5 instance.
module tb_collision_response;

    logic       clk = 1'b0;
    logic       nRst = 1'b0;
    logic       start = 1'b0;
    logic       moveTick = 1'b0;
    logic       goodColl = 1'b0;
    logic       badColl = 1'b0;
    logic       appleAck = 1'b0;

    logic [1:0] b_state, s_state;
    logic       b_grow, s_grow, b_req, s_req;
    logic [6:0] b_len, s_len;
    logic [3:0] b_ones, b_tens, s_ones, s_tens;
    logic       b_over, s_over, b_win, s_win;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    collision_response #(.INIT_LEN(3), .MAX_LEN(120)) u_big (
        .clk(clk), .nRst(nRst), .start(start), .moveTick(moveTick),
        .goodColl(goodColl), .badColl(badColl), .appleAck(appleAck),
        .state(b_state), .grow(b_grow), .appleReq(b_req), .length(b_len),
        .scoreOnes(b_ones), .scoreTens(b_tens),
        .gameOver(b_over), .win(b_win)
    );

    collision_response #(.INIT_LEN(3), .MAX_LEN(5)) u_small (
        .clk(clk), .nRst(nRst), .start(start), .moveTick(moveTick),
        .goodColl(goodColl), .badColl(badColl), .appleAck(appleAck),
        .state(s_state), .grow(s_grow), .appleReq(s_req), .length(s_len),
        .scoreOnes(s_ones), .scoreTens(s_tens),
        .gameOver(s_over), .win(s_win)
    );

    typedef struct {
        logic st, mt, gc, bc, ak;
        logic [1:0] es;
        logic eg, er;
        logic [6:0] el;
        logic [7:0] esc;
    } vec_t;

    typedef struct {
        logic [1:0] st;
        logic g, r;
        logic [6:0] len;
        logic [7:0] sc;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", nm, act, exp);
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic st, mt, gc, bc, ak);
        start = st; moveTick = mt; goodColl = gc;
        badColl = bc; appleAck = ak;
    endtask

    // pop one expected record and compare the long-game instance against it
    task automatic check_big(string tag);
        exp_t e;
        if (sb.size() == 0) begin
            failures++;
            $display("FAIL %s scoreboard empty", tag);
            return;
        end
        e = sb.pop_front();
        chk({tag, " state"}, b_state, e.st);
        chk({tag, " grow"}, b_grow, e.g);
        chk({tag, " req"}, b_req, e.r);
        chk({tag, " len"}, b_len, e.len);
        chk({tag, " score"}, {b_tens, b_ones}, e.sc);
        chk({tag, " over"}, b_over, e.st == 2'd2);
        chk({tag, " win"}, b_win, e.st == 2'd3);
    endtask

    task automatic check_reset(string tag);
        chk({tag, " b_state"}, b_state, 0);
        chk({tag, " b_len"}, b_len, 3);
        chk({tag, " b_score"}, {b_tens, b_ones}, 0);
        chk({tag, " b_grow"}, b_grow, 0);
        chk({tag, " b_req"}, b_req, 0);
        chk({tag, " b_over"}, b_over, 0);
        chk({tag, " b_win"}, b_win, 0);
        chk({tag, " s_state"}, s_state, 0);
        chk({tag, " s_req"}, s_req, 0);
        chk({tag, " s_win"}, s_win, 0);
        chk({tag, " s_len"}, s_len, 3);
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0, 0);
        nRst = 1'b0;
        tick();
        tick();
        nRst = 1'b1;
        tick();
    endtask

    function automatic logic [7:0] bcd(input int k);
        return {4'((k / 10) % 10), 4'(k % 10)};
    endfunction

    initial begin
        int grows;
        exp_t e;

        //          st mt gc bc ak  state g  r  len score
        tbl.push_back('{1,0,0,0,0, 2'd0, 0, 0, 3, 8'h00});
        tbl.push_back('{0,0,0,0,0, 2'd0, 0, 0, 3, 8'h00});
        tbl.push_back('{1,0,0,0,0, 2'd1, 0, 0, 3, 8'h00});
        tbl.push_back('{0,1,0,0,0, 2'd1, 0, 0, 3, 8'h00});
        tbl.push_back('{1,0,0,0,0, 2'd1, 0, 0, 3, 8'h00});
        tbl.push_back('{0,0,1,0,0, 2'd1, 0, 0, 3, 8'h00});
        tbl.push_back('{0,0,0,0,0, 2'd1, 0, 0, 3, 8'h00});
        tbl.push_back('{0,1,0,0,0, 2'd1, 1, 1, 4, 8'h01});
        tbl.push_back('{0,0,1,0,0, 2'd1, 0, 1, 4, 8'h01});
        tbl.push_back('{0,1,1,0,0, 2'd1, 0, 1, 4, 8'h01});
        tbl.push_back('{0,0,0,0,1, 2'd1, 0, 0, 4, 8'h01});
        tbl.push_back('{0,0,1,0,0, 2'd1, 0, 0, 4, 8'h01});
        tbl.push_back('{0,1,1,0,1, 2'd1, 1, 1, 5, 8'h02});
        tbl.push_back('{0,0,0,0,1, 2'd1, 0, 0, 5, 8'h02});
        tbl.push_back('{0,0,0,1,0, 2'd1, 0, 0, 5, 8'h02});
        tbl.push_back('{0,1,1,0,0, 2'd2, 0, 0, 5, 8'h02});
        tbl.push_back('{0,1,1,1,0, 2'd2, 0, 0, 5, 8'h02});
        tbl.push_back('{1,0,0,0,0, 2'd0, 0, 0, 5, 8'h02});
        tbl.push_back('{0,1,1,1,0, 2'd0, 0, 0, 5, 8'h02});
        tbl.push_back('{1,0,0,0,0, 2'd1, 0, 0, 3, 8'h00});
        tbl.push_back('{0,1,1,1,0, 2'd2, 0, 0, 3, 8'h00});
        tbl.push_back('{1,0,0,0,0, 2'd0, 0, 0, 3, 8'h00});
        tbl.push_back('{0,0,0,0,0, 2'd0, 0, 0, 3, 8'h00});
        tbl.push_back('{1,0,0,0,0, 2'd1, 0, 0, 3, 8'h00});
        tbl.push_back('{0,1,1,0,0, 2'd1, 1, 1, 4, 8'h01});
        tbl.push_back('{0,1,0,1,0, 2'd2, 0, 1, 4, 8'h01});
        tbl.push_back('{0,0,0,0,1, 2'd2, 0, 0, 4, 8'h01});
        tbl.push_back('{1,0,0,0,0, 2'd0, 0, 0, 4, 8'h01});
        tbl.push_back('{0,0,0,0,0, 2'd0, 0, 0, 4, 8'h01});
        tbl.push_back('{1,0,0,0,0, 2'd1, 0, 0, 3, 8'h00});
        tbl.push_back('{0,0,0,0,0, 2'd1, 0, 0, 3, 8'h00});

        // start held high through reset must not count as an edge
        drive(1, 0, 0, 0, 0);
        nRst = 1'b0;
        #23;
        check_reset("reset");
        @(posedge clk);
        #1;
        nRst = 1'b1;

        foreach (tbl[i]) begin
            drive(tbl[i].st, tbl[i].mt, tbl[i].gc, tbl[i].bc, tbl[i].ak);
            sb.push_back('{tbl[i].es, tbl[i].eg, tbl[i].er, tbl[i].el, tbl[i].esc});
            tick();
            check_big($sformatf("row%0d", i));
        end

        // goodColl held for 40 cycles across a single moveTick
        grows = 0;
        for (int i = 0; i < 40; i++) begin
            drive(0, i == 20, 1, 0, 0);
            tick();
            if (b_grow) grows++;
        end
        chk("hold40 grows", grows, 1);
        chk("hold40 len", b_len, 4);
        chk("hold40 score", {b_tens, b_ones}, 8'h01);
        chk("hold40 req", b_req, 1);
        drive(0, 0, 0, 0, 1);
        tick();
        drive(0, 0, 0, 0, 0);
        chk("hold40 ack", b_req, 0);

        // MAX_LEN=5 instance reaches WIN on the second apple
        do_reset();
        drive(1, 0, 0, 0, 0);
        tick();
        chk("win start state", s_state, 1);
        chk("win start len", s_len, 3);
        drive(0, 1, 1, 0, 0);
        tick();
        chk("win eat1 len", s_len, 4);
        drive(0, 0, 0, 0, 1);
        tick();
        drive(0, 1, 1, 0, 0);
        tick();
        chk("win eat2 grow", s_grow, 1);
        chk("win eat2 len", s_len, 5);
        chk("win eat2 state", s_state, 3);
        chk("win eat2 win", s_win, 1);
        chk("win eat2 req", s_req, 1);
        drive(0, 1, 1, 1, 0);
        tick();
        chk("win frozen len", s_len, 5);
        chk("win frozen state", s_state, 3);
        chk("win frozen grow", s_grow, 0);
        chk("win frozen score", {s_tens, s_ones}, 8'h02);
        drive(0, 0, 0, 0, 1);
        tick();
        chk("win ack req", s_req, 0);

        // 100 apples: BCD carry through 99 -> 00 while length keeps counting
        do_reset();
        drive(1, 0, 0, 0, 0);
        tick();
        for (int k = 1; k <= 100; k++) begin
            drive(0, 1, 1, 0, 0);
            e = '{2'd1, 1'b1, 1'b1, 7'(3 + k), bcd(k)};
            sb.push_back(e);
            tick();
            check_big($sformatf("eat%0d", k));
            if (k != 100) begin
                drive(0, 0, 0, 0, 1);
                tick();
            end
        end
        drive(0, 0, 0, 0, 0);
        tick();
        chk("pend req", b_req, 1);

        // asynchronous reset mid-cycle with the handshake pending
        #2;
        nRst = 1'b0;
        #1;
        check_reset("async");
        #10;
        nRst = 1'b1;
        tick();
        tick();
        chk("post idle state", b_state, 0);
        chk("post idle req", b_req, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
